// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, parallel load, wrap or saturate
// mode, a zero-latency terminal-count output and sticky overflow/underflow flags.
module updown_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             clear_flags_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_sticky_o,
    output logic             unf_sticky_o
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max, at_zero;
    logic             tc;

    assign at_max  = (count_q == MaxCnt);
    assign at_zero = (count_q == '0);

    // tc marks the edge on which a wrap or saturation happens, in either mode.
    assign tc = enable_i & ~load_i & ~reset_i &
                ((up_dn_i & at_max) | (~up_dn_i & at_zero));

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_value_i > MaxCnt) ? MaxCnt : load_value_i;
        end else if (enable_i) begin
            if (up_dn_i) begin
                if (at_max) begin
                    count_d = SATURATE ? MaxCnt : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_d = SATURATE ? '0 : MaxCnt;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // A set on the same edge as clear_flags wins.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_flags_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (tc & up_dn_i) begin
            ovf_d = 1'b1;
        end
        if (tc & ~up_dn_i) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o      = count_q;
    assign tc_o         = tc;
    assign ovf_sticky_o = ovf_q;
    assign unf_sticky_o = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param at WIDTH=4, MAX_COUNT=9 in wrap (a) and
// saturate (b) configurations.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;

    logic       a_reset, a_en, a_up, a_load, a_clr;
    logic [3:0] a_lv, a_cnt;
    logic       a_tc, a_ovf, a_unf;

    logic       b_reset, b_en, b_up, b_load, b_clr;
    logic [3:0] b_lv, b_cnt;
    logic       b_tc, b_ovf, b_unf;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_wrap (
        .clk_i        (clk),
        .reset_i      (a_reset),
        .enable_i     (a_en),
        .up_dn_i      (a_up),
        .load_i       (a_load),
        .load_value_i (a_lv),
        .clear_flags_i(a_clr),
        .count_o      (a_cnt),
        .tc_o         (a_tc),
        .ovf_sticky_o (a_ovf),
        .unf_sticky_o (a_unf)
    );

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_sat (
        .clk_i        (clk),
        .reset_i      (b_reset),
        .enable_i     (b_en),
        .up_dn_i      (b_up),
        .load_i       (b_load),
        .load_value_i (b_lv),
        .clear_flags_i(b_clr),
        .count_o      (b_cnt),
        .tc_o         (b_tc),
        .ovf_sticky_o (b_ovf),
        .unf_sticky_o (b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks count and both sticky flags of one instance.
    task automatic chk_a(input string tag, input int c, input bit o, input bit u);
        chk({tag, ".cnt"}, 32'(a_cnt), 32'(c));
        chk({tag, ".ovf"}, 32'(a_ovf), 32'(o));
        chk({tag, ".unf"}, 32'(a_unf), 32'(u));
    endtask

    task automatic chk_b(input string tag, input int c, input bit o, input bit u);
        chk({tag, ".cnt"}, 32'(b_cnt), 32'(c));
        chk({tag, ".ovf"}, 32'(b_ovf), 32'(o));
        chk({tag, ".unf"}, 32'(b_unf), 32'(u));
    endtask

    initial begin
        a_reset = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_clr = 1'b0; a_lv = 4'd0;
        b_reset = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0; b_clr = 1'b0; b_lv = 4'd0;

        // ---------------- wrap instance ----------------
        step();
        chk_a("a.reset", 0, 0, 0);
        chk("a.reset.tc", 32'(a_tc), 0);

        // Build up count and both flags, then reset mid-count.
        a_reset = 1'b0; a_en = 1'b1; a_up = 1'b0;
        #1 chk("a.pre_unf.tc", 32'(a_tc), 1);
        step();
        chk_a("a.down_from0", 9, 0, 1);
        a_up = 1'b1;
        step();
        chk_a("a.up_from9", 0, 1, 1);
        step();
        step();
        chk_a("a.count2", 2, 1, 1);
        a_reset = 1'b1; a_up = 1'b0;
        step();
        chk_a("a.rst1", 0, 0, 0);
        chk("a.rst.tc_masked", 32'(a_tc), 0);
        step();
        chk_a("a.rst2", 0, 0, 0);

        // Up wrap: load 7 (enable ignored), then 8,9,0,1.
        a_reset = 1'b0; a_load = 1'b1; a_lv = 4'd7; a_up = 1'b1;
        step();
        chk_a("a.load7", 7, 0, 0);
        a_load = 1'b0;
        #1 chk("a.tc@7", 32'(a_tc), 0);
        step();
        chk_a("a.up8", 8, 0, 0);
        chk("a.tc@8", 32'(a_tc), 0);
        step();
        chk_a("a.up9", 9, 0, 0);
        chk("a.tc@9", 32'(a_tc), 1);
        step();
        chk_a("a.wrap0", 0, 1, 0);
        chk("a.tc@0up", 32'(a_tc), 0);
        step();
        chk_a("a.up1", 1, 1, 0);

        // Down wrap: load 1, then 0,9,8.
        a_load = 1'b1; a_lv = 4'd1; a_up = 1'b0;
        step();
        chk_a("a.load1", 1, 1, 0);
        a_load = 1'b0;
        #1 chk("a.tc@1dn", 32'(a_tc), 0);
        step();
        chk_a("a.dn0", 0, 1, 0);
        chk("a.tc@0dn", 32'(a_tc), 1);
        step();
        chk_a("a.wrap9", 9, 1, 1);
        chk("a.tc@9dn", 32'(a_tc), 0);
        step();
        chk_a("a.dn8", 8, 1, 1);

        // Load priority and clamp; tc masked by load.
        a_load = 1'b1; a_lv = 4'hE; a_up = 1'b1;
        step();
        chk_a("a.clamp", 9, 1, 1);
        chk("a.tc.load_mask", 32'(a_tc), 0);
        a_load = 1'b0; a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("a.hold.cnt", 32'(a_cnt), 9);
        end
        chk("a.hold.tc", 32'(a_tc), 0);

        // Clear race: set wins for ovf, unf clears; then plain clear.
        a_en = 1'b1; a_up = 1'b1; a_clr = 1'b1;
        #1 chk("a.race.tc", 32'(a_tc), 1);
        step();
        chk_a("a.race", 0, 1, 0);
        a_en = 1'b0;
        step();
        chk_a("a.clear", 0, 0, 0);
        a_clr = 1'b0;

        // ---------------- saturate instance ----------------
        step();
        chk_b("b.reset", 0, 0, 0);
        b_reset = 1'b0; b_load = 1'b1; b_lv = 4'd9; b_en = 1'b1;
        step();
        chk_b("b.load9", 9, 0, 0);
        b_load = 1'b0; b_up = 1'b1;
        #1 chk("b.tc@9", 32'(b_tc), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_b("b.sat_hi", 9, 1, 0);
            chk("b.sat_hi.tc", 32'(b_tc), 1);
        end
        b_load = 1'b1; b_lv = 4'd0; b_up = 1'b0;
        step();
        chk_b("b.load0", 0, 1, 0);
        b_load = 1'b0;
        #1 chk("b.tc@0", 32'(b_tc), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_b("b.sat_lo", 0, 1, 1);
        end
        b_up = 1'b1;
        step();
        chk_b("b.up1", 1, 1, 1);
        chk("b.tc@1", 32'(b_tc), 0);
        b_load = 1'b1; b_lv = 4'hF;
        step();
        chk_b("b.clamp", 9, 1, 1);
        b_load = 1'b0; b_en = 1'b0; b_clr = 1'b1;
        step();
        chk_b("b.clear", 9, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
